// File: rtl/pulse_train_gen.sv
// -----------------------------------------------------------------------------
// pulse_train_gen
//
// Generates a programmable train of rising edges on a single registered line
// for a downstream posedge detector. A one-cycle start request (accepted only
// while idle) latches the high-phase length, the low-phase (gap) length and the
// pulse count. The block then drives the waveform by itself and strobes done
// for one cycle as the last pulse falls. There is no trailing low phase after
// the final pulse.
//
// Optional feature: define PULSE_TRAIN_GEN_ABORT_EN to add an abort input that
// cancels a running train. The aborted output strobes for one cycle, and done
// is not raised for that train.
//
// Parameters
//   CNT_W         width of the phase-length fields and phase counter
//   NUM_W         width of the pulse count and pulses_sent
//
// Ports
//   clk_i           system clock, rising edge
//   reset_i         synchronous, active-high reset; discards a running train
//   start_i         start request, ignored while busy_o=1
//   high_len_i      high-phase length in cycles (0 behaves as 1), sampled on accept
//   low_len_i       low-phase length in cycles (0 behaves as 1), sampled on accept
//   num_pulses_i    number of pulses (0 = done strobe only), sampled on accept
//   abort_i         (ABORT_EN only) cancel the running train
//   out_o           generated waveform, registered
//   busy_o          train in progress
//   done_o          one-cycle completion strobe
//   aborted_o       (ABORT_EN only) one-cycle abort strobe
//   pulses_sent_o   rising edges emitted in the current or last train
// -----------------------------------------------------------------------------
module pulse_train_gen #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] high_len_i,
    input  logic [CNT_W-1:0] low_len_i,
    input  logic [NUM_W-1:0] num_pulses_i,
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    input  logic             abort_i,
    output logic             aborted_o,
`endif
    output logic             out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [NUM_W-1:0] pulses_sent_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;     // cycles left in the current phase, minus one
    logic [CNT_W-1:0] high_q,  high_d;    // latched H (already clamped to >= 1)
    logic [CNT_W-1:0] low_q,   low_d;     // latched L (already clamped to >= 1)
    logic [NUM_W-1:0] num_q,   num_d;     // latched N
    logic [NUM_W-1:0] sent_q,  sent_d;
    logic             out_q,   out_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic             abort_w;
    logic [CNT_W-1:0] high_acc;
    logic [CNT_W-1:0] low_acc;

`ifdef PULSE_TRAIN_GEN_ABORT_EN
    logic aborted_q, aborted_d;
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    // A zero-length phase is treated as a one-cycle phase.
    assign high_acc = (high_len_i == '0) ? CNT_W'(1) : high_len_i;
    assign low_acc  = (low_len_i  == '0) ? CNT_W'(1) : low_len_i;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves
        // one unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        high_d  = high_q;
        low_d   = low_q;
        num_d   = num_q;
        sent_d  = sent_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
        aborted_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                // abort is meaningless while idle, so start always wins here.
                if (start_i) begin
                    high_d = high_acc;
                    low_d  = low_acc;
                    num_d  = num_pulses_i;
                    sent_d = '0;
                    if (num_pulses_i != '0) begin
                        state_d = ST_HIGH;
                        out_d   = 1'b1;
                        busy_d  = 1'b1;
                        sent_d  = NUM_W'(1);
                        cnt_d   = high_acc - CNT_W'(1);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            ST_HIGH, ST_LOW: begin
                if (abort_w) begin
                    // Abort takes priority over a phase ending in the same cycle.
                    state_d = ST_IDLE;
                    out_d   = 1'b0;
                    busy_d  = 1'b0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
                    aborted_d = 1'b1;
`endif
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (state_q == ST_HIGH) begin
                    out_d = 1'b0;
                    if (sent_q < num_q) begin
                        state_d = ST_LOW;
                        cnt_d   = low_q - CNT_W'(1);
                    end else begin
                        // Last pulse: return to idle with no trailing gap.
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_HIGH;
                    out_d   = 1'b1;
                    sent_d  = sent_q + NUM_W'(1);
                    cnt_d   = high_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                out_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge value of every other one.
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            high_q  <= '0;
            low_q   <= '0;
            num_q   <= '0;
            sent_q  <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            high_q  <= high_d;
            low_q   <= low_d;
            num_q   <= num_d;
            sent_q  <= sent_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef PULSE_TRAIN_GEN_ABORT_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    assign aborted_o = aborted_q;
`endif

    assign out_o         = out_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pulses_sent_o = sent_q;

endmodule
